// File: rtl/tetris_pkg.sv
// Shared piece encoding for the tetromino sequencer blocks.
package tetris_pkg;
  localparam int PIECE_W    = 3;
  localparam int NUM_PIECES = 7;

  typedef logic [PIECE_W-1:0] piece_t;

  localparam piece_t PIECE_I    = 3'd0;
  localparam piece_t PIECE_O    = 3'd1;
  localparam piece_t PIECE_T    = 3'd2;
  localparam piece_t PIECE_S    = 3'd3;
  localparam piece_t PIECE_Z    = 3'd4;
  localparam piece_t PIECE_J    = 3'd5;
  localparam piece_t PIECE_L    = 3'd6;
  localparam piece_t PIECE_NONE = 3'd7;
endpackage

// File: rtl/bag_tracker.sv
// 7-bag bookkeeping: accepts unused candidates and forces the lowest unused piece
// once STALL_MAX consecutive candidates have been rejected.
module bag_tracker
  import tetris_pkg::*;
#(
  parameter int STALL_MAX = 15
) (
  input  logic   clk,
  input  logic   reset,
  input  piece_t cand,
  input  logic   push_en,
  output piece_t accept_piece,
  output logic   push_valid
);
  localparam int ST_W = $clog2(STALL_MAX + 1);

  logic [NUM_PIECES-1:0] used;
  logic [NUM_PIECES-1:0] used_next;
  logic [ST_W-1:0]       stall_cnt;
  logic                  cand_ok;
  logic                  stall_fire;
  piece_t                lowest;

  assign cand_ok = (cand != PIECE_NONE) && !used[cand];

  always_comb begin
    lowest = PIECE_NONE;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (!used[i]) lowest = piece_t'(i);
    end
  end

  // The fallback fires on the rejection that brings the run up to STALL_MAX.
  assign stall_fire   = !cand_ok && (stall_cnt == ST_W'(STALL_MAX - 1));
  assign push_valid   = push_en && (cand_ok || stall_fire);
  assign accept_piece = cand_ok ? cand : lowest;
  assign used_next    = used | (NUM_PIECES'(1) << accept_piece);

  always_ff @(posedge clk) begin
    if (reset) begin
      used      <= '0;
      stall_cnt <= '0;
    end else if (push_valid) begin
      used      <= (used_next == {NUM_PIECES{1'b1}}) ? '0 : used_next;
      stall_cnt <= '0;
    end else if (push_en) begin
      stall_cnt <= stall_cnt + ST_W'(1);
    end
  end
endmodule

// File: rtl/piece_bag_queue.sv
// Preview queue fed by the 7-bag generator; head pops on spawn.
// Optional hold/swap slot is built only when PIECE_HOLD_EN is defined.
module piece_bag_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int RND_W     = 3,
  parameter int STALL_MAX = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RND_W-1:0]     rnd_in,
  input  logic                 req,
  input  logic                 hold_req,
  output logic                 piece_valid,
  output logic [2:0]           cur_piece,
  output logic [3*(DEPTH-1)-1:0] preview,
  output logic [2:0]           hold_piece
);
  localparam int CNT_W = 3;

  piece_t           q [DEPTH];
  logic [CNT_W-1:0] count;
  logic             push_en;
  logic             push_valid;
  piece_t           accept_piece;
  piece_t           cand;
  logic             do_pop;
  logic             do_swap;
  piece_t           swap_piece;

  assign cand    = rnd_in[2:0];
  assign push_en = (count < CNT_W'(DEPTH));

  bag_tracker #(.STALL_MAX(STALL_MAX)) u_bag (
    .clk          (clk),
    .reset        (reset),
    .cand         (cand),
    .push_en      (push_en),
    .accept_piece (accept_piece),
    .push_valid   (push_valid)
  );

`ifdef PIECE_HOLD_EN
  piece_t hold_q;
  logic   hold_used;
  logic   hold_ok;

  // req has priority; hold is allowed once per spawned piece.
  assign hold_ok    = piece_valid && !req && hold_req && !hold_used;
  assign do_pop     = piece_valid && (req || (hold_ok && hold_q == PIECE_NONE));
  assign do_swap    = hold_ok && (hold_q != PIECE_NONE);
  assign swap_piece = hold_q;
  assign hold_piece = hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= PIECE_NONE;
      hold_used <= 1'b0;
    end else if (piece_valid && req) begin
      hold_used <= 1'b0;
    end else if (hold_ok) begin
      hold_used <= 1'b1;
      hold_q    <= q[0];
    end
  end
`else
  logic unused_hold;
  assign unused_hold = hold_req;
  assign do_pop      = piece_valid && req;
  assign do_swap     = 1'b0;
  assign swap_piece  = PIECE_NONE;
  assign hold_piece  = PIECE_NONE;
`endif

  generate
    if (RND_W > 3) begin : g_rnd_unused
      logic unused_rnd;
      assign unused_rnd = ^rnd_in[RND_W-1:3];
    end
  endgenerate

  // Pushes happen only while filling, pops only while full, so they never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= PIECE_NONE;
      count       <= '0;
      piece_valid <= 1'b0;
    end else if (push_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count == CNT_W'(i)) q[i] <= accept_piece;
      end
      count       <= count + CNT_W'(1);
      piece_valid <= ((count + CNT_W'(1)) == CNT_W'(DEPTH));
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
      q[DEPTH-1]  <= PIECE_NONE;
      count       <= count - CNT_W'(1);
      piece_valid <= 1'b0;
    end else if (do_swap) begin
      q[0] <= swap_piece;
    end
  end

  assign cur_piece = q[0];

  generate
    for (genvar g = 1; g < DEPTH; g++) begin : g_preview
      assign preview[3*(g-1) +: 3] = q[g];
    end
  endgenerate
endmodule
